// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//
// Multi-channel clock divider. Each of the N_CH channels makes its own slow
// clock from the system clock clk, for example a 2 Hz blink, a 1 Hz sample
// strobe or buzzer pacing. A channel has a half-period that can be changed at
// run time, a run/freeze enable, and one-cycle rise/fall ticks. A shared sync
// input restarts every channel so that all of them are phase-aligned.
//
// Parameters
//   N_CH      number of independent divider channels (>= 1)
//   CNT_W     width of each half-period value and of each counter
//   DEF_HALF  half-period in clk cycles loaded at reset (0 is treated as 1)
//
// Ports
//   clk        in   1           system clock; all logic runs on the rising edge
//   rst_n      in   1           asynchronous, active-low reset
//   en         in   N_CH        per-channel run enable; 0 freezes that channel
//   half_per   in   N_CH*CNT_W  half-period in clk cycles; channel k uses
//                               bits [k*CNT_W +: CNT_W]
//   sync       in   1           synchronous restart of all channels
//   clk_out    out  N_CH        divided clock per channel, 50% duty
//   rise_tick  out  N_CH        one-cycle pulse in the cycle clk_out[k] becomes 1
//   fall_tick  out  N_CH        one-cycle pulse in the cycle clk_out[k] becomes 0
// -----------------------------------------------------------------------------
module clk_div_multi #(
    parameter int N_CH     = 2,
    parameter int CNT_W    = 16,
    parameter int DEF_HALF = 250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         en,
    input  logic [N_CH*CNT_W-1:0]   half_per,
    input  logic                    sync,
    output logic [N_CH-1:0]         clk_out,
    output logic [N_CH-1:0]         rise_tick,
    output logic [N_CH-1:0]         fall_tick
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_RAW  = CNT_W'(DEF_HALF);
    // A zero reset half-period would never reach a terminal count, so it is
    // promoted to 1 (fastest rate) exactly like a zero runtime value.
    localparam logic [CNT_W-1:0] DEF_EFF  = (DEF_RAW == '0) ? ONE : DEF_RAW;

    // Half-period actually used: a programmed 0 behaves as 1.
    function automatic logic [CNT_W-1:0] eff_half(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    for (genvar k = 0; k < N_CH; k++) begin : g_ch

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] hp_q,  hp_d;
        logic             out_q, out_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;
        logic [CNT_W-1:0] hp_in;
        logic             terminal;

        assign hp_in = eff_half(half_per[k*CNT_W +: CNT_W]);

        // hp_q >= 1 always, so hp_q - 1 cannot wrap. Using >= rather than ==
        // lets a half-period that shrank while frozen end on the first
        // enabled edge instead of running the counter all the way around.
        assign terminal = (cnt_q >= (hp_q - ONE));

        // Priority: sync, then enable, then counting.
        always_comb begin
            // NOTE: every signal written here gets a default first, so no
            // path through the if/else can leave one unassigned and infer a latch.
            cnt_d  = cnt_q;
            hp_d   = hp_q;
            out_d  = out_q;
            rise_d = 1'b0;
            fall_d = 1'b0;

            if (sync) begin
                // Park low and pick up the new rate; deliberately no fall
                // tick even if the output was high.
                cnt_d = '0;
                out_d = 1'b0;
                hp_d  = hp_in;
            end else if (!en[k]) begin
                // Frozen: counter and level hold, but the shadow rate keeps
                // tracking the input so a new rate applies on resume.
                hp_d = hp_in;
            end else if (terminal) begin
                // Half-period boundary: the only point where a new rate is
                // sampled while running, which keeps rate changes glitch-free.
                cnt_d  = '0;
                out_d  = ~out_q;
                rise_d = ~out_q;
                fall_d =  out_q;
                hp_d   = hp_in;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                hp_q   <= DEF_EFF;
                out_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                hp_q   <= hp_d;
                out_q  <= out_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end

        assign clk_out[k]   = out_q;
        assign rise_tick[k] = rise_q;
        assign fall_tick[k] = fall_q;

    end : g_ch

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
//
// Self-checking bench for clk_div_multi. A behavioural model tracks, per
// channel, how many enabled cycles have elapsed at the current level and which
// half-period length is in force; the output level flips when a full
// half-period has elapsed. Directed scenarios pin the model with hand-computed
// edge counts, then a long randomized run is compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int N_CH     = 2;
    localparam int CNT_W    = 16;
    localparam int DEF_HALF = 250;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       en;
    logic [N_CH*CNT_W-1:0] half_per;
    logic                  sync;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       rise_tick;
    logic [N_CH-1:0]       fall_tick;

    int total = 0;
    int bad   = 0;

    clk_div_multi #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .half_per  (half_per),
        .sync      (sync),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int unsigned m_elapsed [N_CH];   // enabled cycles spent at the current level
    int unsigned m_half    [N_CH];   // half-period length in force
    bit          m_level   [N_CH];
    bit          m_rise    [N_CH];
    bit          m_fall    [N_CH];

    function automatic int unsigned eff(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                m_elapsed[k] = 0;
                m_half[k]    = eff(DEF_HALF);
                m_level[k]   = 1'b0;
                m_rise[k]    = 1'b0;
                m_fall[k]    = 1'b0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                int unsigned req;
                req       = eff(int'(half_per[k*CNT_W +: CNT_W]));
                m_rise[k] = 1'b0;
                m_fall[k] = 1'b0;
                if (sync) begin
                    m_elapsed[k] = 0;
                    m_level[k]   = 1'b0;
                    m_half[k]    = req;
                end else if (!en[k]) begin
                    m_half[k] = req;
                end else if (m_elapsed[k] + 1 >= m_half[k]) begin
                    // This cycle completes the half-period: flip the level.
                    m_elapsed[k] = 0;
                    m_level[k]   = !m_level[k];
                    m_rise[k]    = m_level[k];
                    m_fall[k]    = !m_level[k];
                    m_half[k]    = req;
                end else begin
                    m_elapsed[k] = m_elapsed[k] + 1;
                end
            end
        end
    end

    // Cycle-by-cycle compare, away from the active edge.
    always @(negedge clk) begin
        logic [N_CH-1:0] e_out, e_rise, e_fall;
        for (int k = 0; k < N_CH; k++) begin
            e_out[k]  = m_level[k];
            e_rise[k] = m_rise[k];
            e_fall[k] = m_fall[k];
        end
        check("clk_out",   64'(clk_out),   64'(e_out));
        check("rise_tick", 64'(rise_tick), 64'(e_rise));
        check("fall_tick", 64'(fall_tick), 64'(e_fall));
        check("tick_excl", 64'(rise_tick & fall_tick), 64'(0));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges until clk_out[ch] reaches lvl; -1 if the budget expires.
    task automatic wait_level(input int ch, input bit lvl, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            step();
            n++;
            if (clk_out[ch] === lvl) return;
        end
        n = -1;
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    initial begin
        int n, r0, r1;
        bit prev;

        // Reset default
        rst_n    = 1'b0;
        en       = 2'b11;
        half_per = {16'd0, 16'd250};
        sync     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_out",   64'(clk_out),   64'(0));
        check("rst_rise_tick", 64'(rise_tick), 64'(0));
        check("rst_fall_tick", 64'(fall_tick), 64'(0));
        rst_n = 1'b1;
        wait_level(0, 1'b1, 300, n);
        check("def_rise_edge", 64'(n), 64'(250));
        check("def_rise_tick", 64'(rise_tick[0]), 64'(1));
        wait_level(0, 1'b0, 300, n);
        check("def_fall_edge", 64'(n), 64'(250));
        for (int i = 0; i < 3; i++) begin
            prev = clk_out[1];
            step();
            check("h1_toggle", 64'(clk_out[1]), 64'(!prev));
        end

        // Sync from arbitrary phases
        half_per = {16'd7, 16'd5};
        step(37);
        pulse_sync();
        check("sync_parked", 64'(clk_out), 64'(0));
        check("sync_no_fall", 64'(fall_tick), 64'(0));
        r0 = -1;
        r1 = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (r0 < 0 && clk_out[0]) r0 = i;
            if (r1 < 0 && clk_out[1]) r1 = i;
        end
        check("sync_rise_ch0", 64'(r0), 64'(5));
        check("sync_rise_ch1", 64'(r1), 64'(7));

        // Rate change mid-half-period
        half_per[15:0] = 16'd4;
        pulse_sync();
        step();
        half_per[15:0] = 16'd10;
        wait_level(0, 1'b1, 20, n);
        check("rate_old_half", 64'(n), 64'(3));
        wait_level(0, 1'b0, 30, n);
        check("rate_new_half", 64'(n), 64'(10));
        wait_level(0, 1'b1, 30, n);
        check("rate_new_half2", 64'(n), 64'(10));

        // Freeze while high
        half_per[15:0] = 16'd8;
        pulse_sync();
        wait_level(0, 1'b1, 20, n);
        check("frz_rise", 64'(n), 64'(8));
        step(5);
        en[0] = 1'b0;
        step(20);
        check("frz_hold", 64'(clk_out[0]), 64'(1));
        en[0] = 1'b1;
        wait_level(0, 1'b0, 10, n);
        check("frz_resume_fall", 64'(n), 64'(3));
        check("frz_fall_tick", 64'(fall_tick[0]), 64'(1));

        // Shrink while frozen
        half_per[15:0] = 16'd10;
        pulse_sync();
        wait_level(0, 1'b1, 20, n);
        check("shr_rise", 64'(n), 64'(10));
        step(7);
        en[0] = 1'b0;
        half_per[15:0] = 16'd3;
        step(2);
        en[0] = 1'b1;
        wait_level(0, 1'b0, 10, n);
        check("shr_first_edge", 64'(n), 64'(1));
        wait_level(0, 1'b1, 10, n);
        check("shr_new_half", 64'(n), 64'(3));

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N_CH; k++) begin
                en[k] = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 15) == 0)
                    half_per[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
            end
            sync = ($urandom_range(0, 63) == 0);
            step();
        end
        sync = 1'b0;
        en   = 2'b11;

        // Asynchronous reset while high
        half_per[15:0] = 16'd6;
        pulse_sync();
        wait_level(0, 1'b1, 20, n);
        check("ar_reached_high", 64'(n), 64'(6));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_clk_out", 64'(clk_out), 64'(0));
        check("ar_ticks", 64'(rise_tick | fall_tick), 64'(0));
        step(2);
        rst_n = 1'b1;
        step(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
